// File: rtl/pipelined_tree_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Package : tree_adder_pkg
// Purpose : Shared types and helper functions for pipelined_tree_accumulator.
//           - acc_state_e        : accumulator state machine encoding
//           - lane_ext()         : sign/zero extension of a narrow value
//           - OW_f()             : output width of the accumulator
//           - level_off()        : bit offset of a tree level in the flat bus
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package tree_adder_pkg;

  // Width of the scratch vector used by lane_ext; must exceed any OW in use.
  localparam int EXT_W = 128;

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  // Extend the low from_w bits of value to to_w bits. Bits at and above
  // to_w are returned as zero so callers can take a fixed-width slice.
  function automatic logic [EXT_W-1:0] lane_ext(
    input logic [EXT_W-1:0] value,
    input int               from_w,
    input int               to_w,
    input bit               is_signed
  );
    logic [EXT_W-1:0] r;
    r = '0;
    for (int i = 0; i < EXT_W; i++) begin
      if (i < to_w) begin
        r[i] = (i < from_w) ? value[i] : (is_signed & value[from_w-1]);
      end
    end
    return r;
  endfunction

  function automatic int OW_f(input int log2_n, input int dw, input int acc_bits);
    return dw + log2_n + acc_bits;
  endfunction

  // The tree is kept on one flat bus: level 0 is the raw lanes, level l holds
  // 2**(log2_n-l) values of dw+l bits. Returns the first bit of level lvl.
  function automatic int level_off(input int log2_n, input int dw, input int lvl);
    int off;
    off = 0;
    for (int k = 0; k < lvl; k++) begin
      off += (1 << (log2_n - k)) * (dw + k);
    end
    return off;
  endfunction

endpackage : tree_adder_pkg
`default_nettype wire

// File: rtl/pipelined_tree_accumulator_level.sv
`default_nettype none
// ============================================================================
// Module  : tree_adder_level
// Purpose : One registered level of the balanced adder tree. Adds adjacent
//           lane pairs (0+1, 2+3, ...) with one bit of growth and carries a
//           valid and a last flag alongside the data.
// Ports   : clk     - clock, rising edge
//           rst     - asynchronous active-high reset
//           en_i    - global pipeline advance
//           data_i  - N_IN lanes of W_IN bits, lane i at [(i+1)*W_IN-1:i*W_IN]
//           valid_i / last_i  - flags travelling with data_i
//           data_o  - N_IN/2 sums of W_IN+1 bits
//           valid_o / last_o  - registered flags
// Revision: 1.0 - initial release
// ============================================================================
module tree_adder_level #(
  parameter int N_IN   = 4,
  parameter int W_IN   = 8,
  parameter int SIGNED = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_i,
  input  logic [N_IN*W_IN-1:0]            data_i,
  input  logic                            valid_i,
  input  logic                            last_i,
  output logic [(N_IN/2)*(W_IN+1)-1:0]    data_o,
  output logic                            valid_o,
  output logic                            last_o
);

  localparam int N_OUT = N_IN / 2;
  localparam int W_OUT = W_IN + 1;

  logic [N_OUT*W_OUT-1:0] data_d;
  logic [N_OUT*W_OUT-1:0] data_q;
  logic                   valid_q;
  logic                   last_q;

  for (genvar p = 0; p < N_OUT; p++) begin : g_pair
    logic [W_IN-1:0] a;
    logic [W_IN-1:0] b;
    logic            a_ext;
    logic            b_ext;
    assign a     = data_i[(2*p)*W_IN   +: W_IN];
    assign b     = data_i[(2*p+1)*W_IN +: W_IN];
    // One extra bit per level is enough: the sum of two W_IN values never
    // needs more than W_IN+1 bits, so the tree cannot overflow.
    assign a_ext = (SIGNED != 0) & a[W_IN-1];
    assign b_ext = (SIGNED != 0) & b[W_IN-1];
    assign data_d[p*W_OUT +: W_OUT] = {a_ext, a} + {b_ext, b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (en_i) begin
      data_q  <= data_d;
      valid_q <= valid_i;
      last_q  <= last_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;

endmodule : tree_adder_level
`default_nettype wire

// File: rtl/pipelined_tree_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_tree_accumulator
// Purpose : Reduces 2**LOG2_N lanes per beat to a single sum through a fully
//           pipelined balanced adder tree, optionally accumulating several
//           beats per group (closed by in_last_i), with valid/ready flow
//           control and a beat-count overflow indicator.
// Ports   : clk, rst      - clock (rising edge), asynchronous active-high reset
//           in_data_i     - lanes, lane i at [(i+1)*DW-1:i*DW]
//           in_valid_i    - beat valid
//           in_last_i     - final beat of a group (ignored when ACC_EN=0)
//           in_ready_o    - beat accepted on this edge when in_valid_i is high
//           out_data_o    - group sum, OW bits, extended per SIGNED
//           out_valid_o   - out_data_o/out_ovf_o valid
//           out_ready_i   - downstream accepts
//           out_ovf_o     - group held more than 2**ACC_BITS beats
// Revision: 1.0 - initial release
// ============================================================================
module pipelined_tree_accumulator
  import tree_adder_pkg::*;
#(
  parameter int LOG2_N   = 2,
  parameter int DW       = 8,
  parameter int SIGNED   = 0,
  parameter int ACC_EN   = 1,
  parameter int ACC_BITS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [(2**LOG2_N)*DW-1:0]             in_data_i,
  input  logic                                  in_valid_i,
  input  logic                                  in_last_i,
  output logic                                  in_ready_o,
  output logic [OW_f(LOG2_N, DW, (ACC_EN != 0) ? ACC_BITS : 0)-1:0] out_data_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic                                  out_ovf_o
);

  localparam int N_LANES   = 1 << LOG2_N;
  localparam int AB_EFF    = (ACC_EN != 0) ? ACC_BITS : 0;
  localparam int OW        = OW_f(LOG2_N, DW, AB_EFF);
  localparam int TW        = DW + LOG2_N;
  localparam int TREE_BITS = level_off(LOG2_N, DW, LOG2_N + 1);
  localparam int SUM_OFF   = level_off(LOG2_N, DW, LOG2_N);
  // Count width leaves headroom above 2**AB_EFF so the overflow compare
  // can see "one more than allowed" before the counter saturates.
  localparam int CW        = AB_EFF + 2;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(1 << AB_EFF);

  // ---------------------------------------------------------------------------
  // Flow control: every register in the block advances together.
  // ---------------------------------------------------------------------------
  logic w_en;
  logic out_valid_q;

  assign w_en       = !out_valid_q || out_ready_i;
  assign in_ready_o = w_en;

  // ---------------------------------------------------------------------------
  // Adder tree
  // ---------------------------------------------------------------------------
  wire [TREE_BITS-1:0] w_tree;
  wire [LOG2_N:0]      w_tv;
  wire [LOG2_N:0]      w_tl;

  assign w_tree[0 +: N_LANES*DW] = in_data_i;
  assign w_tv[0]                 = in_valid_i;
  // Without accumulation every beat closes its own group.
  assign w_tl[0]                 = in_last_i | (ACC_EN == 0);

  for (genvar l = 1; l <= LOG2_N; l++) begin : g_level
    localparam int N_IN    = N_LANES >> (l - 1);
    localparam int W_IN    = DW + l - 1;
    localparam int IN_OFF  = level_off(LOG2_N, DW, l - 1);
    localparam int OUT_OFF = level_off(LOG2_N, DW, l);

    tree_adder_level #(
      .N_IN   (N_IN),
      .W_IN   (W_IN),
      .SIGNED (SIGNED)
    ) u_level (
      .clk     (clk),
      .rst     (rst),
      .en_i    (w_en),
      .data_i  (w_tree[IN_OFF +: N_IN*W_IN]),
      .valid_i (w_tv[l-1]),
      .last_i  (w_tl[l-1]),
      .data_o  (w_tree[OUT_OFF +: (N_IN/2)*(W_IN+1)]),
      .valid_o (w_tv[l]),
      .last_o  (w_tl[l])
    );
  end

  // ---------------------------------------------------------------------------
  // Accumulator stage
  // ---------------------------------------------------------------------------
  logic [TW-1:0]    w_sum;
  logic [EXT_W-1:0] w_sum_wide;
  logic [OW-1:0]    w_sum_ext;
  logic             w_unused_ext;
  logic [OW-1:0]    w_acc_next;
  logic [CW-1:0]    w_cnt_next;

  acc_state_e    state_q;
  logic [OW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [OW-1:0] out_data_q;
  logic          out_ovf_q;

  assign w_sum        = w_tree[SUM_OFF +: TW];
  assign w_sum_wide   = lane_ext(EXT_W'(w_sum), TW, OW, SIGNED != 0);
  assign w_sum_ext    = w_sum_wide[OW-1:0];
  assign w_unused_ext = ^w_sum_wide[EXT_W-1:OW];
  // Wraps modulo 2**OW; out_ovf_o flags when this may have happened.
  assign w_acc_next   = acc_q + w_sum_ext;
  assign w_cnt_next   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FIRST;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (w_en) begin
      // Advancing with no new result means the held one was consumed.
      out_valid_q <= 1'b0;
      if (w_tv[LOG2_N]) begin
        case (state_q)
          ST_FIRST: begin
            acc_q <= w_sum_ext;
            cnt_q <= CW'(1);
            if (w_tl[LOG2_N]) begin
              out_data_q  <= w_sum_ext;
              out_valid_q <= 1'b1;
              out_ovf_q   <= 1'b0;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            acc_q <= w_acc_next;
            cnt_q <= w_cnt_next;
            if (w_tl[LOG2_N]) begin
              out_data_q  <= w_acc_next;
              out_valid_q <= 1'b1;
              out_ovf_q   <= (w_cnt_next > CNT_LIMIT);
              state_q     <= ST_FIRST;
            end
          end
          default: state_q <= ST_FIRST;
        endcase
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_ovf_o   = out_ovf_q;

endmodule : pipelined_tree_accumulator
`default_nettype wire
